calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 43 ++++
 rtl/calc_bin2bcd.sv | 48 ++++
 rtl/calc_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator key sequencer: FSM states, key classes,
// ALU operation codes, display constants and small digit helpers.
package calc_pkg;

    localparam int OPND_W = 14;
    localparam int BCD_W  = 16;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_WAIT_ALU = 3'd2,
        ST_CONVERT  = 3'd3,
        ST_SHOW_RES = 3'd4,
        ST_ERROR    = 3'd5
    } calcState_t;

    localparam logic [1:0] KEY_DIGIT  = 2'd0;
    localparam logic [1:0] KEY_OP     = 2'd1;
    localparam logic [1:0] KEY_EQUALS = 2'd2;
    localparam logic [1:0] KEY_CLEAR  = 2'd3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [BCD_W-1:0] DISP_ERROR = 16'hEEEE;

    function automatic logic [OPND_W-1:0] appendDigit(input logic [OPND_W-1:0] bin,
                                                      input logic [3:0] digit);
        return bin * OPND_W'(10) + OPND_W'(digit);
    endfunction

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [BCD_W-1:0] bcdAdd3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < BCD_W / 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Serial double-dabble binary-to-BCD converter: load on start, 14 shift cycles,
// then a one-cycle done pulse with the BCD result held on bcd.
module calc_bin2bcd
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [OPND_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              done
);

    logic [OPND_W-1:0] shiftBin;
    logic [3:0]        bitCnt;
    logic              busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shiftBin <= '0;
            bcd      <= '0;
            bitCnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            bitCnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (start) begin
            shiftBin <= bin;
            bcd      <= '0;
            bitCnt   <= 4'(OPND_W);
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (busy) begin
            {bcd, shiftBin} <= {bcdAdd3(bcd), shiftBin} << 1;
            bitCnt          <= bitCnt - 4'd1;
            if (bitCnt == 4'd1) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator key sequencer: collects two operands from key events, drives the ALU
// handshake, converts the result to BCD and feeds the display with change-driven loads.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [1:0]        key_type,
    input  logic [3:0]        key_digit,
    input  logic [1:0]        key_op,
    output logic [OPND_W-1:0] op_a,
    output logic [OPND_W-1:0] op_b,
    output logic [1:0]        alu_op,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [OPND_W-1:0] alu_result,
    input  logic              alu_error,
    output logic [BCD_W-1:0]  disp_bcd,
    output logic              disp_load,
    input  logic              disp_busy,
    output logic [2:0]        state,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);

    calcState_t        curState, stateN;
    logic [OPND_W-1:0] opABin, opABinN, opBBin, opBBinN;
    logic [BCD_W-1:0]  opABcd, opABcdN, opBBcd, opBBcdN;
    logic [CNT_W-1:0]  opACnt, opACntN, opBCnt, opBCntN;
    logic [1:0]        aluOpN, pendOp, pendOpN;
    logic              fromOp, fromOpN, aluStartN;
    logic [TMO_W-1:0]  waitCnt, waitCntN;
    logic [BCD_W-1:0]  shownVal, shownN, convBcd;
    logic              pending, convStart, convDone;
    logic              keyDigit, keyOp, keyEq, keyClr, shownChanged;

    assign keyDigit = key_valid && (key_type == KEY_DIGIT) && (key_digit <= 4'd9);
    assign keyOp    = key_valid && (key_type == KEY_OP);
    assign keyEq    = key_valid && (key_type == KEY_EQUALS);
    assign keyClr   = key_valid && (key_type == KEY_CLEAR);

    assign op_a  = opABin;
    assign op_b  = opBBin;
    assign state = curState;
    assign err   = (curState == ST_ERROR);

    calc_bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (convStart),
        .abort (keyClr),
        .bin   (alu_result),
        .bcd   (convBcd),
        .done  (convDone)
    );

    always_comb begin
        stateN    = curState;
        opABinN   = opABin;
        opABcdN   = opABcd;
        opACntN   = opACnt;
        opBBinN   = opBBin;
        opBBcdN   = opBBcd;
        opBCntN   = opBCnt;
        aluOpN    = alu_op;
        pendOpN   = pendOp;
        fromOpN   = fromOp;
        waitCntN  = waitCnt;
        aluStartN = 1'b0;
        convStart = 1'b0;

        // Clear wins over everything, including an alu_done in the same cycle.
        if (keyClr) begin
            stateN   = ST_ENTER_A;
            opABinN  = '0;
            opABcdN  = '0;
            opACntN  = '0;
            opBBinN  = '0;
            opBBcdN  = '0;
            opBCntN  = '0;
            aluOpN   = '0;
            pendOpN  = '0;
            fromOpN  = 1'b0;
            waitCntN = '0;
        end else begin
            case (curState)
                ST_ENTER_A: begin
                    if (keyDigit && (opACnt < CNT_W'(MAX_DIGITS))) begin
                        opABinN = appendDigit(opABin, key_digit);
                        opABcdN = {opABcd[BCD_W-5:0], key_digit};
                        opACntN = opACnt + CNT_W'(1);
                    end else if (keyOp) begin
                        aluOpN  = key_op;
                        opBBinN = '0;
                        opBBcdN = '0;
                        opBCntN = '0;
                        stateN  = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (keyDigit && (opBCnt < CNT_W'(MAX_DIGITS))) begin
                        opBBinN = appendDigit(opBBin, key_digit);
                        opBBcdN = {opBBcd[BCD_W-5:0], key_digit};
                        opBCntN = opBCnt + CNT_W'(1);
                    end else if (keyOp && (opBCnt == '0)) begin
                        aluOpN = key_op;
                    end else if (keyOp || (keyEq && (opBCnt != '0))) begin
                        aluStartN = 1'b1;
                        pendOpN   = key_op;
                        fromOpN   = keyOp;
                        waitCntN  = '0;
                        stateN    = ST_WAIT_ALU;
                    end
                end
                ST_WAIT_ALU: begin
                    if (alu_done) begin
                        if (alu_error) begin
                            stateN = ST_ERROR;
                        end else begin
                            opABinN   = alu_result;
                            convStart = 1'b1;
                            stateN    = ST_CONVERT;
                        end
                    end else if (waitCnt == TMO_W'(ALU_TIMEOUT - 1)) begin
                        stateN = ST_ERROR;
                    end else begin
                        waitCntN = waitCnt + TMO_W'(1);
                    end
                end
                ST_CONVERT: begin
                    if (convDone) begin
                        opABcdN = convBcd;
                        if (fromOp) begin
                            aluOpN  = pendOp;
                            opBBinN = '0;
                            opBBcdN = '0;
                            opBCntN = '0;
                            stateN  = ST_ENTER_B;
                        end else begin
                            stateN = ST_SHOW_RES;
                        end
                    end
                end
                ST_SHOW_RES: begin
                    if (keyDigit) begin
                        opABinN = OPND_W'(key_digit);
                        opABcdN = BCD_W'(key_digit);
                        opACntN = CNT_W'(1);
                        stateN  = ST_ENTER_A;
                    end else if (keyOp) begin
                        aluOpN  = key_op;
                        opBBinN = '0;
                        opBBcdN = '0;
                        opBCntN = '0;
                        stateN  = ST_ENTER_B;
                    end
                end
                ST_ERROR: ;
                default: stateN = ST_ENTER_A;
            endcase
        end

        case (stateN)
            ST_ENTER_A:  shownN = opABcdN;
            ST_ENTER_B:  shownN = opBBcdN;
            ST_SHOW_RES: shownN = opABcdN;
            ST_ERROR:    shownN = DISP_ERROR;
            default:     shownN = shownVal;
        endcase
    end

    assign shownChanged = (shownN != shownVal);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curState  <= ST_ENTER_A;
            opABin    <= '0;
            opABcd    <= '0;
            opACnt    <= '0;
            opBBin    <= '0;
            opBBcd    <= '0;
            opBCnt    <= '0;
            alu_op    <= '0;
            pendOp    <= '0;
            fromOp    <= 1'b0;
            waitCnt   <= '0;
            alu_start <= 1'b0;
            shownVal  <= '0;
            pending   <= 1'b1;
            disp_bcd  <= '0;
            disp_load <= 1'b0;
        end else begin
            curState  <= stateN;
            opABin    <= opABinN;
            opABcd    <= opABcdN;
            opACnt    <= opACntN;
            opBBin    <= opBBinN;
            opBBcd    <= opBBcdN;
            opBCnt    <= opBCntN;
            alu_op    <= aluOpN;
            pendOp    <= pendOpN;
            fromOp    <= fromOpN;
            waitCnt   <= waitCntN;
            alu_start <= aluStartN;
            shownVal  <= shownN;
            // A change arriving in the same cycle as a load stays pending for the next one.
            if (pending && !disp_busy) begin
                disp_bcd  <= shownVal;
                disp_load <= 1'b1;
                pending   <= shownChanged;
            end else begin
                disp_load <= 1'b0;
                pending   <= pending | shownChanged;
            end
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: key sequences with a scripted ALU responder.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [1:0]  key_type;
    logic [3:0]  key_digit;
    logic [1:0]  key_op;
    logic [13:0] op_a, op_b;
    logic [1:0]  alu_op;
    logic        alu_start, alu_done, alu_error;
    logic [13:0] alu_result;
    logic [15:0] disp_bcd;
    logic        disp_load, disp_busy;
    logic [2:0]  state;
    logic        err;

    int testsRun = 0;
    int testsFailed = 0;
    int startCnt = 0;
    int loadCnt = 0;
    int base = 0;

    calc_sequencer #(.MAX_DIGITS(4), .ALU_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_type(key_type), .key_digit(key_digit), .key_op(key_op),
        .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .alu_error(alu_error),
        .disp_bcd(disp_bcd), .disp_load(disp_load), .disp_busy(disp_busy),
        .state(state), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (alu_start === 1'b1) startCnt <= startCnt + 1;
        if (disp_load === 1'b1) loadCnt <= loadCnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] t, input logic [3:0] d, input logic [1:0] o);
        @(negedge clk);
        key_valid = 1'b1; key_type = t; key_digit = d; key_op = o;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pressDigit(input logic [3:0] d); press(KEY_DIGIT, d, 2'd0); endtask
    task automatic pressOp(input logic [1:0] o);    press(KEY_OP, 4'd0, o);    endtask
    task automatic pressEq();                       press(KEY_EQUALS, 4'd0, 2'd0); endtask
    task automatic pressClr();                      press(KEY_CLEAR, 4'd0, 2'd0);  endtask

    task automatic aluRespond(input logic [13:0] res, input logic e);
        int waited = 0;
        while (alu_start !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("alu_start_seen", 32'(alu_start), 32'd1);
        tick(3);
        alu_done = 1'b1; alu_result = res; alu_error = e;
        @(negedge clk);
        alu_done = 1'b0; alu_error = 1'b0;
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; key_type = 2'd0; key_digit = 4'd0; key_op = 2'd0;
        alu_done = 1'b0; alu_result = '0; alu_error = 1'b0; disp_busy = 1'b0;

        // Reset state
        tick(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_op_a", 32'(op_a), 32'd0);
        check("rst_op_b", 32'(op_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_disp_bcd", 32'(disp_bcd), 32'd0);
        check("rst_disp_load", 32'(disp_load), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        tick(3);
        check("post_rst_zero_load", 32'(loadCnt), 32'd1);
        check("post_rst_disp", 32'(disp_bcd), 32'd0);

        // 12 + 34 = 46
        base = startCnt;
        pressDigit(4'd1); pressDigit(4'd2); pressOp(OP_ADD);
        pressDigit(4'd3); pressDigit(4'd4); pressEq();
        check("add_op_a", 32'(op_a), 32'd12);
        check("add_op_b", 32'(op_b), 32'd34);
        check("add_wait_state", 32'(state), 32'd2);
        aluRespond(14'd46, 1'b0);
        check("conv_enter", 32'(state), 32'd3);
        tick(14);
        check("conv_cycle15", 32'(state), 32'd3);
        tick(1);
        check("conv_exit", 32'(state), 32'd4);
        tick(4);
        check("add_disp", 32'(disp_bcd), 32'h0046);
        check("add_result_op_a", 32'(op_a), 32'd46);
        check("add_one_start", 32'(startCnt - base), 32'd1);

        // Digit limit and invalid digit
        pressClr();
        pressDigit(4'd1); pressDigit(4'd2); pressDigit(4'd11);
        check("bad_digit_ignored", 32'(op_a), 32'd12);
        pressDigit(4'd3); pressDigit(4'd4); pressDigit(4'd5);
        tick(3);
        check("limit_op_a", 32'(op_a), 32'd1234);
        check("limit_disp", 32'(disp_bcd), 32'h1234);
        check("limit_state", 32'(state), 32'd0);

        // Operator replacement: 5 + - 3 =
        pressClr();
        base = startCnt;
        pressDigit(4'd5); pressOp(OP_ADD); pressOp(OP_SUB);
        check("replace_op", 32'(alu_op), 32'(OP_SUB));
        check("replace_state", 32'(state), 32'd1);
        pressDigit(4'd3); pressEq();
        aluRespond(14'd2, 1'b0);
        tick(20);
        check("replace_alu_op", 32'(alu_op), 32'(OP_SUB));
        check("replace_one_start", 32'(startCnt - base), 32'd1);
        check("replace_show", 32'(state), 32'd4);
        check("replace_disp", 32'(disp_bcd), 32'h0002);

        // Chaining: 9 + 1 * -> 10 with '*' pending, then 3 =
        pressClr();
        base = startCnt;
        pressDigit(4'd9); pressOp(OP_ADD); pressDigit(4'd1); pressOp(OP_MUL);
        check("chain_wait", 32'(state), 32'd2);
        check("chain_op_held", 32'(alu_op), 32'(OP_ADD));
        aluRespond(14'd10, 1'b0);
        tick(20);
        check("chain_state", 32'(state), 32'd1);
        check("chain_op_a", 32'(op_a), 32'd10);
        check("chain_alu_op", 32'(alu_op), 32'(OP_MUL));
        check("chain_op_b", 32'(op_b), 32'd0);
        check("chain_one_start", 32'(startCnt - base), 32'd1);
        pressDigit(4'd3); pressEq();
        aluRespond(14'd30, 1'b0);
        tick(20);
        check("chain_second_start", 32'(startCnt - base), 32'd2);
        check("chain_disp", 32'(disp_bcd), 32'h0030);

        // Clear beats a simultaneous alu_done
        pressClr();
        pressDigit(4'd7); pressOp(OP_ADD); pressDigit(4'd8); pressEq();
        tick(2);
        @(negedge clk);
        key_valid = 1'b1; key_type = KEY_CLEAR; alu_done = 1'b1; alu_result = 14'd99;
        @(negedge clk);
        key_valid = 1'b0; alu_done = 1'b0;
        check("clr_prio_state", 32'(state), 32'd0);
        check("clr_prio_op_a", 32'(op_a), 32'd0);
        tick(20);
        check("clr_prio_stays", 32'(state), 32'd0);

        // ALU timeout
        pressDigit(4'd7); pressOp(OP_ADD); pressDigit(4'd8); pressEq();
        tick(250);
        check("tmo_still_wait", 32'(state), 32'd2);
        tick(10);
        check("tmo_error", 32'(state), 32'd5);
        check("tmo_err_flag", 32'(err), 32'd1);
        tick(3);
        check("tmo_disp", 32'(disp_bcd), 32'hEEEE);
        pressDigit(4'd3);
        check("err_digit_ignored", 32'(state), 32'd5);
        pressClr();
        tick(3);
        check("err_clr_state", 32'(state), 32'd0);
        check("err_clr_disp", 32'(disp_bcd), 32'd0);
        check("err_clr_flag", 32'(err), 32'd0);

        // ALU error flag
        pressDigit(4'd1); pressOp(OP_DIV); pressDigit(4'd2); pressEq();
        aluRespond(14'd0, 1'b1);
        tick(2);
        check("alu_error_state", 32'(state), 32'd5);
        pressClr();
        tick(3);

        // Display busy coalescing
        disp_busy = 1'b1;
        base = loadCnt;
        pressDigit(4'd4); pressDigit(4'd5);
        tick(5);
        check("busy_no_load", 32'(loadCnt - base), 32'd0);
        check("busy_disp_held", 32'(disp_bcd), 32'd0);
        disp_busy = 1'b0;
        tick(4);
        check("busy_single_load", 32'(loadCnt - base), 32'd1);
        check("busy_latest", 32'(disp_bcd), 32'h0045);

        // Reset abandons an ALU wait
        pressClr();
        pressDigit(4'd1); pressOp(OP_ADD); pressDigit(4'd2); pressEq();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wait_state", 32'(state), 32'd0);
        check("rst_wait_start", 32'(alu_start), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(20);
        check("rst_wait_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
